// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: received-word handshake bundle.
// master = receiver side, slave = downstream consumer.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 7
);
  logic [DATA_BITS-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    output data_out,
    output valid_out,
    output frame_err,
    output parity_err,
    input  ready_in
  );

  modport slave (
    input  data_out,
    input  valid_out,
    input  frame_err,
    input  parity_err,
    output ready_in
  );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled LSB-first UART receiver, 3-sample vote.
// Optional parity bit: define UART_RX_PARITY_EN.
module uart_rx_core #(
  parameter int DATA_BITS  = 7,
  parameter int OVERSAMPLE = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                rx,
  uart_rx_core_if.master      rxo,
  output logic                overrun,
  output logic [2:0]          state_out
);

  localparam int M   = OVERSAMPLE / 2;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);

  localparam logic [SCW-1:0] SC_A   = SCW'(M - 1);
  localparam logic [SCW-1:0] SC_B   = SCW'(M);
  localparam logic [SCW-1:0] SC_V   = SCW'(M + 1);
  localparam logic [SCW-1:0] SC_END = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LST = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] SB_LST = BCW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [SCW-1:0]       sc;
  logic [BCW-1:0]       bc;
  logic                 s0;
  logic                 s1;
  logic [DATA_BITS-1:0] shreg;
  logic                 ferr_p;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                 perr_p;
  logic                 perr_q;
`endif

  logic vote;
  logic accept;
  logic done;

  assign vote   = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign accept = valid_q & rxo.ready_in;
  assign done   = ena && (state == STOP) &&
                  (sc == SC_V) && (bc == SB_LST);

  // Line idles high, so the synchroniser resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sc      <= '0;
      bc      <= '0;
      s0      <= 1'b0;
      s1      <= 1'b0;
      shreg   <= '0;
      ferr_p  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_p  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      if (accept) valid_q <= 1'b0;
      // A held, unaccepted word wins; the new frame is dropped.
      if (done) begin
        if (!valid_q || accept) begin
          data_q  <= shreg;
          ferr_q  <= ferr_p | ~vote;
          valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_q  <= perr_p;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end
      if (ena) begin
        if (state != IDLE) begin
          if (sc == SC_A) s0 <= rx_s;
          if (sc == SC_B) s1 <= rx_s;
          sc <= (sc == SC_END) ? '0 : sc + 1'b1;
        end
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state  <= START;
              sc     <= '0;
              ferr_p <= 1'b0;
`ifdef UART_RX_PARITY_EN
              perr_p <= 1'b0;
`endif
            end
          end
          START: begin
            if (sc == SC_V && vote) begin
              state <= IDLE;
              sc    <= '0;
            end else if (sc == SC_END) begin
              state <= DATA;
              bc    <= '0;
            end
          end
          DATA: begin
            if (sc == SC_V)
              shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (sc == SC_END) begin
              if (bc == BC_LST) begin
                bc <= '0;
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bc <= bc + 1'b1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (sc == SC_V)
              perr_p <= vote ^ (^shreg) ^ PARITY_ODD;
            if (sc == SC_END) state <= STOP;
          end
`endif
          STOP: begin
            if (sc == SC_V && !vote) ferr_p <= 1'b1;
            // Finish at the last vote to resync early.
            if (sc == SC_V && bc == SB_LST) begin
              state <= IDLE;
              sc    <= '0;
              bc    <= '0;
            end else if (sc == SC_END) begin
              bc <= bc + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rxo.data_out  = data_q;
  assign rxo.valid_out = valid_q;
  assign rxo.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rxo.parity_err = perr_q;
`else
  assign rxo.parity_err = 1'b0;
  wire   unused_parity_odd = PARITY_ODD;
`endif
  assign state_out = state;

endmodule
